pc_branch_fetch: RTL and testbench

// - Program-counter/fetch sequencer; the reading end of the branch LUT interface.
// - Drives the 5-bit LUT index and consumes the returned absolute target, one cycle later.
// - Presents fetch PC to instruction memory; handles start, sequential step, LUT branch, halt.

---
 rtl/pc_pkg.sv | 8 +
 rtl/pc_branch_fetch.sv | 90 +++++++++
 tb/tb_pc_branch_fetch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, PC type and fetch FSM states for the fetch sequencer.
package pc_pkg;
    localparam int PC_W      = 10;
    localparam int LUT_AW    = 5;
    localparam int PGM_DEPTH = 512;
    typedef logic [PC_W-1:0] pc_t;
    typedef enum logic [1:0] {IDLE, RUN, BR_WAIT, DONE} fetch_st_e;
endpackage

// File: rtl/pc_branch_fetch.sv
// pc_branch_fetch: PC/fetch sequencer driving the branch LUT index and taking its target.
// Define PC_BOUNDS_CHK_EN to trap any next PC at or beyond PGM_DEPTH.
module pc_branch_fetch
    import pc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_addr,
    input  logic              branch_req,
    input  logic [LUT_AW-1:0] branch_idx,
    input  logic              halt,
    output logic [LUT_AW-1:0] lut_idx,
    input  logic [PC_W-1:0]   lut_target,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_valid,
    output logic              busy,
    output logic              done,
    output logic              bound_err
);
    fetch_st_e         state_q, state_d;
    pc_t               pc_q, pc_d, nxt;
    logic [LUT_AW-1:0] lut_idx_q, lut_idx_d;
    logic              bound_err_q, bound_err_d, ld;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        lut_idx_d   = lut_idx_q;
        bound_err_d = bound_err_q;
        nxt         = '0;
        ld          = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                nxt = start_addr;
                ld  = 1'b1;
            end
            RUN: if (halt) begin
                state_d = DONE;
            end else if (branch_req) begin
                lut_idx_d = branch_idx;
                state_d   = BR_WAIT;
            end else begin
                nxt = pc_q + 1'b1;
                ld  = 1'b1;
            end
            BR_WAIT: begin
                nxt = lut_target;
                ld  = 1'b1;
            end
            default: ;
        endcase
        // every PC load funnels through here so the bounds trap sees all sources
        if (ld) begin
`ifdef PC_BOUNDS_CHK_EN
            if ({1'b0, nxt} >= (PC_W+1)'(PGM_DEPTH)) begin
                bound_err_d = 1'b1;
                state_d     = DONE;
            end else begin
                pc_d    = nxt;
                state_d = RUN;
            end
`else
            pc_d    = nxt;
            state_d = RUN;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            lut_idx_q   <= '0;
            bound_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            lut_idx_q   <= lut_idx_d;
            bound_err_q <= bound_err_d;
        end
    end

    assign pc          = pc_q;
    assign lut_idx     = lut_idx_q;
    assign fetch_valid = state_q == RUN;
    assign busy        = state_q == RUN || state_q == BR_WAIT;
    assign done        = state_q == DONE;
    assign bound_err   = bound_err_q;
endmodule

// File: tb/tb_pc_branch_fetch.sv
// tb_pc_branch_fetch: directed checks of start, step, LUT branch, halt, wrap and reset.
module tb_pc_branch_fetch;
    import pc_pkg::*;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [PC_W-1:0]   start_addr = '0;
    logic              branch_req = 1'b0;
    logic [LUT_AW-1:0] branch_idx = '0;
    logic              halt = 1'b0;
    logic [LUT_AW-1:0] lut_idx;
    logic [PC_W-1:0]   lut_target;
    logic [PC_W-1:0]   pc;
    logic              fetch_valid, busy, done, bound_err;
    logic [PC_W-1:0]   lut [32];
    int checks = 0;
    int failures = 0;

    pc_branch_fetch dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .branch_req(branch_req), .branch_idx(branch_idx), .halt(halt),
        .lut_idx(lut_idx), .lut_target(lut_target), .pc(pc),
        .fetch_valid(fetch_valid), .busy(busy), .done(done), .bound_err(bound_err)
    );

    always #5 clk = ~clk;
    assign lut_target = lut[lut_idx];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_run(input string tag, input int exp_pc);
        check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        check({tag, "_fv"}, 32'(fetch_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) lut[i] = PC_W'(i * 10);
        lut[2] = 10'd99;
        lut[4] = 10'd202;
        step();
        step();
        check("rst_pc", 32'(pc), 0);
        check("rst_fv", 32'(fetch_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_idx", 32'(lut_idx), 0);
        check("rst_err", 32'(bound_err), 0);
        reset = 1'b0;
        step();
        check("idle_hold_pc", 32'(pc), 0);
        check("idle_hold_fv", 32'(fetch_valid), 0);
        start = 1'b1; start_addr = 10'd0;
        step();
        start = 1'b0;
        chk_run("start0", 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_run("seq", i);
        end
        step();
        step();
        chk_run("pre_br", 7);
        branch_req = 1'b1; branch_idx = 5'd2;
        step();
        branch_req = 1'b0;
        check("br_bubble_fv", 32'(fetch_valid), 0);
        check("br_bubble_pc", 32'(pc), 7);
        check("br_idx", 32'(lut_idx), 2);
        check("br_busy", 32'(busy), 1);
        step();
        chk_run("br_tgt", 99);
        step();
        chk_run("br_step", 100);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_done", 32'(done), 1);
        check("halt_pc", 32'(pc), 100);
        start = 1'b1; start_addr = 10'd18;
        step();
        start = 1'b0;
        chk_run("restart18", 18);
        check("restart_done", 32'(done), 0);
        step();
        step();
        chk_run("at20", 20);
        branch_req = 1'b1; branch_idx = 5'd5; halt = 1'b1;
        step();
        branch_req = 1'b0; halt = 1'b0;
        check("prio_done", 32'(done), 1);
        check("prio_pc", 32'(pc), 20);
        check("prio_idx", 32'(lut_idx), 2);
        check("prio_fv", 32'(fetch_valid), 0);
        check("prio_busy", 32'(busy), 0);
        step();
        check("done_hold_pc", 32'(pc), 20);
        check("done_hold", 32'(done), 1);
        start = 1'b1; start_addr = 10'd99;
        step();
        start_addr = 10'd5;
        chk_run("done_start", 99);
        check("done_clr", 32'(done), 0);
        step();
        start = 1'b0;
        chk_run("run_start_ign", 100);
        halt = 1'b1;
        step();
        halt = 1'b0;
`ifdef PC_BOUNDS_CHK_EN
        start = 1'b1; start_addr = 10'd511;
        step();
        start = 1'b0;
        chk_run("bnd_511", 511);
        step();
        check("bnd_err", 32'(bound_err), 1);
        check("bnd_done", 32'(done), 1);
        check("bnd_pc", 32'(pc), 511);
        start = 1'b1; start_addr = 10'd0;
        step();
        start = 1'b0;
        chk_run("bnd_restart", 0);
        check("bnd_sticky", 32'(bound_err), 1);
`else
        start = 1'b1; start_addr = 10'd1022;
        step();
        start = 1'b0;
        chk_run("wrap_1022", 1022);
        step();
        chk_run("wrap_1023", 1023);
        step();
        chk_run("wrap_0", 0);
        check("wrap_err", 32'(bound_err), 0);
`endif
        branch_req = 1'b1; branch_idx = 5'd4;
        step();
        branch_req = 1'b0;
        check("rbw_fv", 32'(fetch_valid), 0);
        check("rbw_idx", 32'(lut_idx), 4);
        reset = 1'b1;
        #1;
        check("rbw_pc", 32'(pc), 0);
        check("rbw_idx0", 32'(lut_idx), 0);
        check("rbw_busy", 32'(busy), 0);
        check("rbw_err", 32'(bound_err), 0);
        step();
        reset = 1'b0;
        step();
        check("rbw_idle_pc", 32'(pc), 0);
        check("rbw_idle_fv", 32'(fetch_valid), 0);
        start = 1'b1; start_addr = 10'd10;
        step();
        start = 1'b0;
        chk_run("post_rst_start", 10);
        step();
        chk_run("post_rst_step", 11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
